// File: rtl/player_pkg.sv
// -----------------------------------------------------------------------------
// player_pkg
// Shared types, widths and helper functions for the player block.
//   player_state_t : jump/gravity state (ground, rising, falling)
//   XW / YW        : pixel x / y coordinate widths
//   PW             : signed position arithmetic width (headroom for y + vel)
//   VW             : signed velocity width, positive means moving down
//   SCREEN_W/H     : visible resolution of the VGA raster
// -----------------------------------------------------------------------------
package player_pkg;

    typedef enum logic [1:0] {
        ST_GROUND = 2'd0,
        ST_RISE   = 2'd1,
        ST_FALL   = 2'd2
    } player_state_t;

    localparam int XW = 10;
    localparam int YW = 9;
    localparam int PW = 11;
    localparam int VW = 8;

    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;

    // Apply one frame of gravity and cap the downward speed. The sum is
    // formed at position width so vel + grav cannot wrap before the cap.
    function automatic logic signed [VW-1:0] vel_step(
        input logic signed [PW-1:0] vel,
        input logic signed [PW-1:0] grav,
        input logic signed [PW-1:0] cap
    );
        logic signed [PW-1:0] sum;
        sum = vel + grav;
        if (sum > cap) begin
            sum = cap;
        end else begin
            sum = sum;
        end
        return sum[VW-1:0];
    endfunction

    // Half-open interval test lo <= v < hi on unsigned position-width values.
    function automatic logic in_span(
        input logic [PW-1:0] v,
        input logic [PW-1:0] lo,
        input logic [PW-1:0] hi
    );
        return (v >= lo) && (v < hi);
    endfunction

endpackage

// File: rtl/player_hitbox.sv
// -----------------------------------------------------------------------------
// player_hitbox
// Combinational rectangle test: is pixel (x_i, y_i) inside the player's box
// whose top edge is loc_i and whose left edge is fixed at PlayerOffset?
// All compares are done at PW bits so loc_i + PlayerHeight never overflows.
// Ports:
//   loc_i    : player top-edge y
//   x_i, y_i : current pixel coordinate
//   in_box_o : 1 when the pixel lies inside the hitbox
// -----------------------------------------------------------------------------
module player_hitbox
    import player_pkg::*;
#(
    parameter int PlayerWidth  = 40,
    parameter int PlayerHeight = 60,
    parameter int PlayerOffset = 0
) (
    input  logic [YW-1:0] loc_i,
    input  logic [XW-1:0] x_i,
    input  logic [YW-1:0] y_i,
    output logic          in_box_o
);

    localparam logic [PW-1:0] X_LO   = PW'(PlayerOffset);
    localparam logic [PW-1:0] X_HI   = PW'(PlayerOffset + PlayerWidth);
    localparam logic [PW-1:0] HEIGHT = PW'(PlayerHeight);

    logic [PW-1:0] x_ext_s;
    logic [PW-1:0] y_ext_s;
    logic [PW-1:0] top_s;
    logic [PW-1:0] bottom_s;
    logic          in_x_s;
    logic          in_y_s;

    // Widen the coordinates and evaluate both axis spans.
    always_comb begin
        x_ext_s  = {{(PW-XW){1'b0}}, x_i};
        y_ext_s  = {{(PW-YW){1'b0}}, y_i};
        top_s    = {{(PW-YW){1'b0}}, loc_i};
        bottom_s = top_s + HEIGHT;
        in_x_s   = in_span(x_ext_s, X_LO, X_HI);
        in_y_s   = in_span(y_ext_s, top_s, bottom_s);
        in_box_o = in_x_s & in_y_s;
    end

endmodule

// File: rtl/player_motion.sv
// -----------------------------------------------------------------------------
// player_motion
// Owns the player's vertical position and draws its hitbox. A jump/gravity
// state machine advances the top-edge y once per video frame; a registered
// per-pixel region flag feeds the colour mux.
// Ports:
//   clk_i        : pixel clock
//   rst_i        : asynchronous active-high reset (player back on the ground)
//   frame_tick_i : one-cycle pulse per frame, start of vblank
//   jump_i       : synchronised jump request (level or pulse)
//   freeze_i     : game over / pause, motion halts and requests are dropped
//   x_i, y_i     : current pixel coordinate
//   luc_loc_o    : player top-edge y, changes only on a frame tick
//   region_o     : current pixel inside hitbox, one cycle after x_i/y_i
//   airborne_o   : player is rising or falling
// -----------------------------------------------------------------------------
module player_motion
    import player_pkg::*;
#(
    parameter int PlayerHeight = 60,
    parameter int PlayerWidth  = 40,
    parameter int PlayerOffset = 0,
    parameter int GroundY      = 400,
    parameter int JumpVel      = 12,
    parameter int Gravity      = 1,
    parameter int MaxFall      = 12
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          frame_tick_i,
    input  logic          jump_i,
    input  logic          freeze_i,
    input  logic [XW-1:0] x_i,
    input  logic [YW-1:0] y_i,
    output logic [YW-1:0] luc_loc_o,
    output logic          region_o,
    output logic          airborne_o
);

    localparam logic signed [PW-1:0] GROUND_Y_S = PW'(GroundY);
    localparam logic signed [PW-1:0] JUMP_VEL_S = PW'(JumpVel);
    localparam logic signed [PW-1:0] GRAVITY_S  = PW'(Gravity);
    localparam logic signed [PW-1:0] MAX_FALL_S = PW'(MaxFall);
    localparam logic        [YW-1:0] GROUND_LOC = GROUND_Y_S[YW-1:0];

    player_state_t          state_r;
    logic [YW-1:0]          y_r;
    logic signed [VW-1:0]   vel_r;
    logic                   jump_pend_r;
    logic                   airborne_r;
    logic                   region_r;

    logic                   jump_req_s;
    logic                   step_s;
    logic                   move_s;
    logic signed [PW-1:0]   y_cur_s;
    logic signed [PW-1:0]   vel_cur_s;
    logic signed [PW-1:0]   y_cand_s;
    logic signed [VW-1:0]   vel_cand_s;
    logic                   hit_s;

    // Candidate position/velocity for this frame, before ground and ceiling
    // resolution. A request in the same cycle as the tick counts for it.
    always_comb begin
        jump_req_s = jump_pend_r | jump_i;
        step_s     = frame_tick_i & ~freeze_i;
        y_cur_s    = {{(PW-YW){1'b0}}, y_r};
        vel_cur_s  = {{(PW-VW){vel_r[VW-1]}}, vel_r};
        y_cand_s   = y_cur_s;
        vel_cand_s = vel_r;
        move_s     = 1'b0;
        case (state_r)
            ST_GROUND: begin
                // Launch always starts from the ground line, not from y_r.
                y_cand_s   = GROUND_Y_S - JUMP_VEL_S;
                vel_cand_s = VW'(GRAVITY_S - JUMP_VEL_S);
                move_s     = step_s & jump_req_s;
            end
            ST_RISE, ST_FALL: begin
                y_cand_s   = y_cur_s + vel_cur_s;
                vel_cand_s = vel_step(vel_cur_s, GRAVITY_S, MAX_FALL_S);
                move_s     = step_s;
            end
            default: begin
                // Unreachable encoding: land on the next tick to recover.
                y_cand_s   = GROUND_Y_S;
                vel_cand_s = {VW{1'b0}};
                move_s     = step_s;
            end
        endcase
    end

    // Jump/gravity state machine: resolve the candidate against the ground
    // (first) and the top of the screen (second) on each live frame tick.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r    <= ST_GROUND;
            y_r        <= GROUND_LOC;
            vel_r      <= {VW{1'b0}};
            airborne_r <= 1'b0;
        end else if (move_s) begin
            if (y_cand_s >= GROUND_Y_S) begin
                state_r    <= ST_GROUND;
                y_r        <= GROUND_LOC;
                vel_r      <= {VW{1'b0}};
                airborne_r <= 1'b0;
            end else if (y_cand_s[PW-1] == 1'b1) begin
                // Hit the ceiling: pin to row 0 and start falling from rest.
                state_r    <= ST_FALL;
                y_r        <= {YW{1'b0}};
                vel_r      <= {VW{1'b0}};
                airborne_r <= 1'b1;
            end else begin
                state_r    <= (vel_cand_s[VW-1] == 1'b1) ? ST_RISE : ST_FALL;
                y_r        <= y_cand_s[YW-1:0];
                vel_r      <= vel_cand_s;
                airborne_r <= 1'b1;
            end
        end
    end

    // Jump request latch: lives only until the next frame tick, and is
    // dropped continuously while frozen so nothing fires on release.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            jump_pend_r <= 1'b0;
        end else if (freeze_i | frame_tick_i) begin
            jump_pend_r <= 1'b0;
        end else if (jump_i) begin
            jump_pend_r <= 1'b1;
        end
    end

    player_hitbox #(
        .PlayerWidth  (PlayerWidth),
        .PlayerHeight (PlayerHeight),
        .PlayerOffset (PlayerOffset)
    ) u_hitbox (
        .loc_i    (y_r),
        .x_i      (x_i),
        .y_i      (y_i),
        .in_box_o (hit_s)
    );

    // Hitbox flag register; uses the position held before this edge, which
    // only moves during vblank, so the drawn box never tears.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            region_r <= 1'b0;
        end else begin
            region_r <= hit_s;
        end
    end

    assign luc_loc_o  = y_r;
    assign airborne_o = airborne_r;
    assign region_o   = region_r;

endmodule

// File: doc/player_motion.md
# player_motion

Parametrised player block for the VGA game: it owns the player's vertical position and draws the player's hitbox. A jump/gravity state machine advances the top-edge y-coordinate `luc_loc_o` once per video frame. The block produces a registered per-pixel `region_o` for the pixel mux. It sits between the button synchroniser / frame-tick generator and the colour mux, and its `luc_loc_o` also feeds collision logic.

## Interface
Parameters:
- `PlayerHeight`, 60: hitbox height, pixels
- `PlayerWidth`, 40: hitbox width, pixels
- `PlayerOffset`, 0: fixed left x of hitbox
- `GroundY`, 400: top-edge y when standing; must satisfy GroundY + PlayerHeight ≤ 480
- `JumpVel`, 12: initial upward speed, px/frame, 1..127
- `Gravity`, 1: speed increment per frame, ≥1
- `MaxFall`, 12: downward speed cap, px/frame, ≤127

Ports:
- `clk_i`, in, 1: pixel clock
- `rst_i`, in, 1: asynchronous, active-high reset
- `frame_tick_i`, in, 1: one-cycle pulse per frame (start of vblank)
- `jump_i`, in, 1: synchronised jump request, level or pulse
- `freeze_i`, in, 1: game over / pause; motion halts
- `x_i`, in, 10: current pixel x
- `y_i`, in, 9: current pixel y
- `luc_loc_o`, out, 9: player top-edge y
- `region_o`, out, 1: current pixel lies inside hitbox (registered)
- `airborne_o`, out, 1: state ≠ GROUND

## Operation
- State: GROUND, RISE, FALL. Velocity `vel` is signed 8-bit, positive = downward. Position arithmetic is done as signed 11-bit.
- `jump_pend` is set in any cycle with `jump_i`=1. It is cleared on every frame tick, whether consumed or not. A request while airborne is discarded; there is no double jump or buffering across ticks. `jump_i` and `frame_tick_i` asserted in the same cycle count for that tick.
- On frame tick with `freeze_i`=0:
  - **GROUND with pending jump:** y_next = GroundY − JumpVel, vel ← −JumpVel + Gravity.
  - **RISE/FALL:** y_next = y + vel, vel ← min(vel + Gravity, MaxFall).
- Resolve y_next in this priority order, including in the jump-launch case:
  1. y_next ≥ GroundY: y ← GroundY, vel ← 0, GROUND.
  2. y_next < 0: y ← 0, vel ← 0, FALL (ceiling).
  3. Otherwise: y ← y_next, state ← RISE if new vel < 0, else FALL.
- GROUND without a pending jump: everything holds.
- `freeze_i`=1: frame ticks are ignored; y, vel and state hold, and `jump_pend` is cleared every cycle.
- Hitbox test uses 11-bit compares so that `luc_loc_o` + PlayerHeight cannot overflow:
  - (x_i ≥ PlayerOffset) & (x_i < PlayerOffset + PlayerWidth)
  - (y_i ≥ luc_loc_o) & (y_i < luc_loc_o + PlayerHeight)

## Timing
- Reset values (asynchronous): state GROUND, `luc_loc_o` = GroundY, vel = 0, `jump_pend` = 0, `region_o` = 0, `airborne_o` = 0.
- Reset mid-jump returns the player to ground immediately, with no wait for a tick.
- `luc_loc_o`, `airborne_o` and `state` update on the clock edge where `frame_tick_i` is sampled high, so they are valid the cycle after.
- `region_o` has a latency of 1 cycle from `x_i`/`y_i`. The pixel pipeline delays sync by 1 to match.
- `region_o` uses the `luc_loc_o` value registered before the edge. Position changes only during vblank, so no tearing occurs.
- Non-tick cycles affect only `jump_pend` and `region_o`.

## Structure
- Package `player_pkg` holds:
  - state enum `player_state_t` (GROUND, RISE, FALL)
  - width constants XW = 10, YW = 9, PW = 11 (signed position), VW = 8 (velocity)
  - screen constants 640/480
- Sub-module `player_hitbox`: combinational rectangle compare, parameters PlayerWidth/PlayerHeight/PlayerOffset, inputs loc/x/y.
- The top level registers the output of `player_hitbox` to produce `region_o`.

## Test plan
- **Reset:** assert `rst_i` asynchronously mid-cycle → `luc_loc_o`=400, `airborne_o`=0, `region_o`=0 immediately. Then x=20, y=420 → `region_o`=1 one cycle later. x=40 or y=460 → 0.
- **Full jump (defaults):** jump pulse, then ticks → y: 388, 377, 367 … 322 at tick 12; then 322, 323 … lands at 400 on tick 25. `airborne_o`=1 for ticks 1–24, 0 from tick 25.
- **Jump while airborne:** `jump_i` at tick 5 → ignored; landing still occurs at tick 25. `jump_i` held high through landing → new launch on tick 26 (y=388).
- **Ceiling clamp:** GroundY=40, JumpVel=60 → first tick y=0, vel=0, FALL. Next tick y=0, vel=1, then y increases until it reaches 40.
- **Freeze:** `freeze_i`=1 at apex with jump pending → position held across 10 ticks, `jump_pend` cleared. Release → fall resumes from the held vel.
- **Simultaneous `jump_i` + `frame_tick_i`:** launch on that tick. Request one cycle after the tick → launch on the next tick.
